// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, read-source tag encoding and the tag record that travels
// down the read-return pipe of the memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_D  = 1'b1
    } src_e;

    typedef struct packed {
        logic valid;
        src_e src;
    } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register that carries {valid, src} alongside each
// outstanding memory read so the returning word reaches the right requester.
module mem_rd_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int LOAD_LATENCY = 1
) (
    input  logic    clk,
    input  logic    clr,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    if (LOAD_LATENCY < 1) begin : g_bad_latency
        $error("mem_rd_tag_pipe: LOAD_LATENCY must be at least 1");
    end

    rd_tag_t stage_q [LOAD_LATENCY];

    always_ff @(posedge clk) begin
        if (clr) begin
            // NOTE: every stage is cleared, not only the output one; a stale
            // valid bit left mid-pipe would surface as a phantom rvalid later.
            for (int i = 0; i < LOAD_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= tag_in;
            for (int i = 1; i < LOAD_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_out = stage_q[LOAD_LATENCY-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: data port wins by default, a streak cap bounds
// fetch starvation, read data is steered back using a tag pipe.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LOAD_LATENCY    = 1,
    parameter int ACTUAL_ADDR_W   = 13,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     if_req,
    input  logic [ADDR_W-1:0]        if_addr,
    output logic                     if_gnt,
    output logic                     if_rvalid,
    output logic [DATA_W-1:0]        if_rdata,
    input  logic                     d_req,
    input  logic [BE_W-1:0]          d_we,
    input  logic [ADDR_W-1:0]        d_addr,
    input  logic [DATA_W-1:0]        d_wdata,
    output logic                     d_gnt,
    output logic                     d_rvalid,
    output logic [DATA_W-1:0]        d_rdata,
    output logic [ACTUAL_ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]          mem_we,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_CAP = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;
    logic                pick_d, pick_if;
    logic [ADDR_W-1:0]   grant_addr;
    logic                unused_addr_bits;
    rd_tag_t             tag_in, tag_out;

    always_comb begin
        // NOTE: every output of this block is assigned a default up front so
        // that no path through the conditionals can infer a latch.
        pick_d     = 1'b0;
        pick_if    = 1'b0;
        grant_addr = '0;
        streak_d   = streak_q;

        if (!rst) begin
            pick_d  = d_req && !(if_req && streak_q == STREAK_CAP);
            pick_if = if_req && !pick_d;
        end

        if (pick_d) begin
            grant_addr = d_addr;
        end else if (pick_if) begin
            grant_addr = if_addr;
        end

        // The streak only counts data wins that actually kept a fetch waiting.
        if (!if_req || pick_if) begin
            streak_d = '0;
        end else if (pick_d && streak_q != STREAK_CAP) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for all clocked state, so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    assign tag_in.valid = pick_if || (pick_d && d_we == '0);
    assign tag_in.src   = pick_d ? SRC_D : SRC_IF;

    mem_rd_tag_pipe #(
        .LOAD_LATENCY (LOAD_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .clr     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign if_gnt    = pick_if;
    assign d_gnt     = pick_d;
    assign mem_addr  = grant_addr[ACTUAL_ADDR_W-1:0];
    assign mem_we    = pick_d ? d_we : '0;
    assign mem_wdata = d_wdata;

    // Requester addresses are wider than the physical memory; the top bits are dropped.
    assign unused_addr_bits = ^grant_addr[ADDR_W-1:ACTUAL_ADDR_W];

    assign if_rvalid = tag_out.valid && tag_out.src == SRC_IF;
    assign d_rvalid  = tag_out.valid && tag_out.src == SRC_D;
    assign if_rdata  = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table, hand-written
// latency/reset sequences and randomized traffic against a scoreboard model.
module tb_mem_port_arbiter;

    localparam int L   = 2;
    localparam int AW  = 13;
    localparam int CAP = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b1;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req = 1'b1;
    logic [3:0]  d_we = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic [12:0] mem_addr;
    logic [3:0]  mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .LOAD_LATENCY    (L),
        .ACTUAL_ADDR_W   (AW),
        .MAX_DATA_STREAK (CAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    function automatic logic [31:0] init_word(input logic [12:0] a);
        return {16'hC0DE, 3'b000, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] we,
                                          input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Write-first memory with L cycles of read latency.
    logic [31:0] mem_arr [int];
    logic [31:0] rpipe [L];
    always @(posedge clk) begin
        logic [31:0] w;
        int          a;
        a = int'(mem_addr);
        w = mem_arr.exists(a) ? mem_arr[a] : init_word(mem_addr);
        w = merge(w, mem_we, mem_wdata);
        if (mem_we != 4'h0) mem_arr[a] = w;
        rpipe[0] <= w;
        for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[L-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic r, input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        cyc++;
        rst = r; if_req = ir; if_addr = ia; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        #2;
    endtask

    task automatic idle(input logic r);
        drive(r, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        d_req;
        logic [3:0]  d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        exp_if_gnt;
        logic        exp_d_gnt;
        logic [12:0] exp_mem_addr;
        logic [3:0]  exp_mem_we;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic [3:0] dwe, input logic [31:0] da, input logic [31:0] dwd,
                                input logic eif, input logic ed, input logic [12:0] ema,
                                input logic [3:0] emwe);
        vec_t v;
        v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd;
        v.exp_if_gnt = eif; v.exp_d_gnt = ed; v.exp_mem_addr = ema; v.exp_mem_we = emwe;
        return v;
    endfunction

    typedef struct {
        logic        src_d;
        logic [31:0] data;
        int          due;
    } rd_exp_t;

    logic [31:0] shadow [int];

    function automatic logic [31:0] shadow_rd(input logic [31:0] a);
        int k;
        k = int'(a[12:0]);
        return shadow.exists(k) ? shadow[k] : init_word(a[12:0]);
    endfunction

    function automatic logic [31:0] rnd_addr();
        return ($urandom & 32'hFFFF_E000) | (32'h40 + 32'($urandom_range(0, 15)));
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    vecs[$];
        rd_exp_t rdq[$];
        int      t0;
        int      fetch_wait;
        logic    if_pend, d_pend, exp_if, exp_d, exp_ifv, exp_dv;
        logic [31:0] ia, da, dwd, exp_data;
        logic [3:0]  dwe;
        logic [12:0] exp_ma;

        // Reset held with both requesters asking: nothing may be granted.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b1, 32'h10, 1'b1, 4'hF, 32'h20, 32'h1);
            check("rst_if_gnt", 32'(if_gnt), 32'd0);
            check("rst_d_gnt", 32'(d_gnt), 32'd0);
            check("rst_mem_we", 32'(mem_we), 32'd0);
            check("rst_mem_addr", 32'(mem_addr), 32'd0);
        end
        for (int i = 0; i < L + 2; i++) begin
            idle(1'b0);
            check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
            check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        end

        // Fetch-only stream of four back-to-back reads.
        t0 = cyc + 1;
        for (int j = 0; j < 8; j++) begin
            drive(1'b0, j < 4, 32'h10 + 32'(j), 1'b0, 4'h0, 32'h0, 32'h0);
            if (j < 4) begin
                check("fetch_gnt", 32'(if_gnt), 32'd1);
                check("fetch_mem_addr", 32'(mem_addr), 32'h10 + 32'(j));
            end
            exp_ifv = (cyc - t0 >= L) && (cyc - t0 < L + 4);
            check("fetch_if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
            check("fetch_d_rvalid", 32'(d_rvalid), 32'd0);
            if (exp_ifv) check("fetch_rdata", if_rdata, init_word(13'(32'h10 + 32'(cyc - t0 - L))));
        end

        // Directed grant table, starting from a fresh streak count.
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 32'h100, 1, 4'h0, 32'h200 + 32'(i), 32'h0, 0, 1, 13'(32'h200 + 32'(i)), 4'h0));
        vecs.push_back(mk(1, 32'h100, 1, 4'h0, 32'h204, 32'h0, 1, 0, 13'h100, 4'h0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 32'h100, 1, 4'h0, 32'h204 + 32'(i), 32'h0, 0, 1, 13'(32'h204 + 32'(i)), 4'h0));
        vecs.push_back(mk(1, 32'h100, 1, 4'h0, 32'h208, 32'h0, 1, 0, 13'h100, 4'h0));
        vecs.push_back(mk(1, 32'h100, 1, 4'h0, 32'h208, 32'h0, 0, 1, 13'h208, 4'h0));
        vecs.push_back(mk(0, 32'h100, 1, 4'h0, 32'h209, 32'h0, 0, 1, 13'h209, 4'h0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1, 32'h100, 1, 4'h0, 32'h20A + 32'(i), 32'h0, 0, 1, 13'(32'h20A + 32'(i)), 4'h0));
        vecs.push_back(mk(1, 32'h100, 1, 4'h0, 32'h20E, 32'h0, 1, 0, 13'h100, 4'h0));
        vecs.push_back(mk(0, 32'h0, 0, 4'h0, 32'h0, 32'h5555_AAAA, 0, 0, 13'h0, 4'h0));
        vecs.push_back(mk(0, 32'h0, 1, 4'h0, 32'h0001_2345, 32'h0, 0, 1, 13'h0345, 4'h0));
        vecs.push_back(mk(0, 32'h0, 1, 4'h5, 32'hFFFF_FFFF, 32'h1234_5678, 0, 1, 13'h1FFF, 4'h5));
        vecs.push_back(mk(1, 32'hABCD_0123, 0, 4'h0, 32'h0, 32'h0, 1, 0, 13'h0123, 4'h0));
        vecs.push_back(mk(1, 32'h100, 1, 4'hF, 32'h50, 32'hCAFE_F00D, 0, 1, 13'h0050, 4'hF));

        idle(1'b1);
        idle(1'b1);
        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].if_req, vecs[i].if_addr, vecs[i].d_req, vecs[i].d_we,
                  vecs[i].d_addr, vecs[i].d_wdata);
            check($sformatf("vec%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].exp_if_gnt));
            check($sformatf("vec%0d_d_gnt", i), 32'(d_gnt), 32'(vecs[i].exp_d_gnt));
            check($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].exp_mem_addr));
            check($sformatf("vec%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].exp_mem_we));
            check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].d_wdata);
        end

        // Store then load of the same word on consecutive cycles.
        for (int i = 0; i < L + 1; i++) idle(1'b0);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF);
        t0 = cyc;
        check("st_d_gnt", 32'(d_gnt), 32'd1);
        check("st_mem_we", 32'(mem_we), 32'hF);
        check("st_mem_addr", 32'(mem_addr), 32'h20);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h20, 32'h0);
        check("ld_d_gnt", 32'(d_gnt), 32'd1);
        check("ld_mem_we", 32'(mem_we), 32'd0);
        check("ld_d_rvalid_early", 32'(d_rvalid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            exp_dv = (cyc == t0 + 1 + L);
            check("stld_d_rvalid", 32'(d_rvalid), 32'(exp_dv));
            check("stld_if_rvalid", 32'(if_rvalid), 32'd0);
            if (exp_dv) check("stld_rdata", d_rdata, 32'hDEAD_BEEF);
        end

        // Reset asserted the cycle after a load grant flushes its return.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 4'h0, 32'h24, 32'h0);
        check("midrst_d_gnt", 32'(d_gnt), 32'd1);
        idle(1'b1);
        for (int i = 0; i < 2; i++) begin
            idle(1'b0);
            check("midrst_d_rvalid", 32'(d_rvalid), 32'd0);
            check("midrst_if_rvalid", 32'(if_rvalid), 32'd0);
        end

        // Randomized traffic against the scoreboard model.
        idle(1'b1);
        idle(1'b1);
        fetch_wait = 0;
        if_pend = 1'b0; d_pend = 1'b0;
        ia = '0; da = '0; dwe = '0; dwd = '0;
        for (int n = 0; n < 1200; n++) begin
            if (!if_pend && $urandom_range(0, 3) != 0) begin
                if_pend = 1'b1;
                ia = rnd_addr();
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1'b1;
                da = rnd_addr();
                dwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                dwd = $urandom;
            end
            drive(1'b0, if_pend, ia, d_pend, dwe, da, dwd);

            // Data wins unless the pending fetch has already waited CAP data grants.
            exp_d  = d_pend && !(if_pend && fetch_wait >= CAP);
            exp_if = if_pend && !exp_d;
            exp_ma = exp_d ? da[12:0] : (exp_if ? ia[12:0] : 13'h0);
            check("rnd_if_gnt", 32'(if_gnt), 32'(exp_if));
            check("rnd_d_gnt", 32'(d_gnt), 32'(exp_d));
            check("rnd_mem_addr", 32'(mem_addr), 32'(exp_ma));
            check("rnd_mem_we", 32'(mem_we), exp_d ? 32'(dwe) : 32'd0);

            exp_ifv = 1'b0; exp_dv = 1'b0; exp_data = '0;
            if (rdq.size() > 0 && rdq[0].due == cyc) begin
                exp_ifv  = !rdq[0].src_d;
                exp_dv   = rdq[0].src_d;
                exp_data = rdq[0].data;
                void'(rdq.pop_front());
            end
            check("rnd_if_rvalid", 32'(if_rvalid), 32'(exp_ifv));
            check("rnd_d_rvalid", 32'(d_rvalid), 32'(exp_dv));
            if (exp_ifv) check("rnd_if_rdata", if_rdata, exp_data);
            if (exp_dv) check("rnd_d_rdata", d_rdata, exp_data);

            fetch_wait = (if_pend && exp_d) ? fetch_wait + 1 : 0;
            if (exp_if) begin
                rdq.push_back('{src_d: 1'b0, data: shadow_rd(ia), due: cyc + L});
                if_pend = 1'b0;
            end
            if (exp_d) begin
                if (dwe == 4'h0) rdq.push_back('{src_d: 1'b1, data: shadow_rd(da), due: cyc + L});
                else shadow[int'(da[12:0])] = merge(shadow_rd(da), dwe, dwd);
                d_pend = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
